// File: rtl/mul_pkg.sv
// Shared types and elaboration helpers for the iterative multiplier.
package mul_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic int calc_iters(input int width, input int radix);
      return width / radix;
   endfunction

   // A legal configuration consumes the operand in whole slices of 1, 2 or 4 bits.
   function automatic bit radix_legal(input int width, input int radix);
      return ((radix == 1) || (radix == 2) || (radix == 4)) &&
             (width > radix) && ((width % radix) == 0);
   endfunction

endpackage

// File: rtl/mul_radix_step.sv
// One CALC step: adds the shifted partial product of a multiplier slice into the accumulator.
module mul_radix_step #(
   parameter int DATA_WIDTH = 32,
   parameter int RADIX_BITS = 2,
   parameter int CW         = 4
) (
   input  logic [2*DATA_WIDTH-1:0] acc,
   input  logic [DATA_WIDTH-1:0]   mcand_mag,
   input  logic [RADIX_BITS-1:0]   slice,
   input  logic [CW-1:0]           count,
   output logic [2*DATA_WIDTH-1:0] acc_next
);

   logic [DATA_WIDTH+RADIX_BITS-1:0] partial;
   logic [2*DATA_WIDTH-1:0]          partial_ext;

   always_comb begin
      partial     = {{RADIX_BITS{1'b0}}, mcand_mag} * {{DATA_WIDTH{1'b0}}, slice};
      partial_ext = {{(DATA_WIDTH-RADIX_BITS){1'b0}}, partial};
      acc_next    = acc + (partial_ext << (int'(count) * RADIX_BITS));
   end

endmodule

// File: rtl/seq_multiplier.sv
// Iterative signed/unsigned multiplier retiring RADIX_BITS multiplier bits per cycle,
// with valid/ready on both sides and a synchronous flush.
//   state | meaning
//   IDLE  | waiting for operands, in_ready high
//   CALC  | ITERS accumulate cycles, inputs ignored
//   DONE  | product held with out_valid until consumed
module seq_multiplier
   import mul_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int RADIX_BITS = 2
) (
   input  logic                    clock,
   input  logic                    reset_n,
   input  logic                    flush,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic                    is_signed,
   input  logic [DATA_WIDTH-1:0]   multiplicand,
   input  logic [DATA_WIDTH-1:0]   multiplier,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [2*DATA_WIDTH-1:0] product,
   output logic                    busy
);

   localparam int ITERS = calc_iters(DATA_WIDTH, RADIX_BITS);
   localparam int CW    = (ITERS > 1) ? $clog2(ITERS) : 1;
   localparam logic [CW-1:0] LAST = CW'(ITERS - 1);

   if (!radix_legal(DATA_WIDTH, RADIX_BITS)) begin : g_bad_cfg
      $error("seq_multiplier: DATA_WIDTH must be a multiple of RADIX_BITS (1, 2 or 4)");
   end

   state_t                  state;
   logic [DATA_WIDTH-1:0]   mcand_mag;
   logic [DATA_WIDTH-1:0]   mplier_mag;
   logic [DATA_WIDTH-1:0]   a_mag;
   logic [DATA_WIDTH-1:0]   b_mag;
   logic                    neg;
   logic [CW-1:0]           count;
   logic [2*DATA_WIDTH-1:0] acc;
   logic [2*DATA_WIDTH-1:0] acc_next;
   logic [2*DATA_WIDTH-1:0] result;
   logic                    accept;

   assign a_mag    = (is_signed && multiplicand[DATA_WIDTH-1]) ? -multiplicand : multiplicand;
   assign b_mag    = (is_signed && multiplier[DATA_WIDTH-1])   ? -multiplier   : multiplier;
   assign in_ready = !flush && ((state == IDLE) || ((state == DONE) && out_ready));
   assign accept   = in_valid && in_ready;
   assign busy     = (state != IDLE);
   assign result   = neg ? -acc_next : acc_next;

   // Multiplier magnitude is shifted right each cycle so the live slice is always the LSBs.
   mul_radix_step #(
      .DATA_WIDTH (DATA_WIDTH),
      .RADIX_BITS (RADIX_BITS),
      .CW         (CW)
   ) u_step (
      .acc       (acc),
      .mcand_mag (mcand_mag),
      .slice     (mplier_mag[RADIX_BITS-1:0]),
      .count     (count),
      .acc_next  (acc_next)
   );

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         mcand_mag  <= '0;
         mplier_mag <= '0;
         neg        <= 1'b0;
         count      <= '0;
         acc        <= '0;
         product    <= '0;
         out_valid  <= 1'b0;
      end else if (flush) begin
         state     <= IDLE;
         out_valid <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if ((state == DONE) && out_ready) begin
                  out_valid <= 1'b0;
                  state     <= IDLE;
               end
               // Back-to-back: a DONE handshake and a new accept can share one edge.
               if (accept) begin
                  mcand_mag  <= a_mag;
                  mplier_mag <= b_mag;
                  neg        <= is_signed && (multiplicand[DATA_WIDTH-1] ^ multiplier[DATA_WIDTH-1]);
                  count      <= '0;
                  acc        <= '0;
                  state      <= CALC;
               end
            end
            CALC: begin
               acc        <= acc_next;
               mplier_mag <= mplier_mag >> RADIX_BITS;
               count      <= count + CW'(1);
               if (count == LAST) begin
                  product   <= result;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed checks on an 8-bit/radix-2 instance plus concurrent random traffic on
// 32-bit instances with radix 1, 2 and 4 against an arithmetic reference.
module tb_seq_multiplier;

   localparam int N_OPS     = 400;
   localparam int RND_LIMIT = 40000;

   logic clk;
   int   n_checks;
   int   n_fail;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b, input logic s);
      if (s) return 64'(longint'($signed(a)) * longint'($signed(b)));
      return {32'b0, a} * {32'b0, b};
   endfunction

   function automatic logic [31:0] rand_opnd();
      case ($urandom_range(0, 7))
         0: return 32'h0000_0000;
         1: return 32'h0000_0001;
         2: return 32'h8000_0000;
         3: return 32'hFFFF_FFFF;
         4: return 32'h7FFF_FFFF;
         default: return $urandom();
      endcase
   endfunction

   // ---------------- 8-bit directed instance ----------------
   logic        rst8, flush8, in_valid8, in_ready8, is_signed8;
   logic        out_valid8, out_ready8, busy8;
   logic [7:0]  a8, b8;
   logic [15:0] product8;

   seq_multiplier #(.DATA_WIDTH(8), .RADIX_BITS(2)) dut8 (
      .clock        (clk),
      .reset_n      (rst8),
      .flush        (flush8),
      .in_valid     (in_valid8),
      .in_ready     (in_ready8),
      .is_signed    (is_signed8),
      .multiplicand (a8),
      .multiplier   (b8),
      .out_valid    (out_valid8),
      .out_ready    (out_ready8),
      .product      (product8),
      .busy         (busy8)
   );

   // Presents operands at a negedge and returns just after the accept edge.
   task automatic start_op8(input logic s, input logic [7:0] a, input logic [7:0] b, input logic ordy);
      @(negedge clk);
      is_signed8 = s;
      a8         = a;
      b8         = b;
      out_ready8 = ordy;
      in_valid8  = 1'b1;
      #1;
      check_eq("accept_ready", 64'(in_ready8), 64'd1);
      @(posedge clk);
   endtask

   // Counts negedges after the accept edge until out_valid; 0 means it never came.
   task automatic wait_out8(output int lat, output bit busy_all);
      lat      = 0;
      busy_all = 1'b1;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (k == 1) in_valid8 = 1'b0;
         #1;
         busy_all &= busy8;
         if (out_valid8) begin
            lat = k;
            break;
         end
      end
   endtask

   typedef struct {
      logic        s;
      logic [7:0]  a;
      logic [7:0]  b;
      logic [15:0] exp;
   } vec8_t;

   // ---------------- 32-bit random instances ----------------
   logic rst_r;

   for (genvar g = 0; g < 3; g++) begin : g_rnd
      localparam int R = (g == 0) ? 1 : ((g == 1) ? 2 : 4);
      logic        in_valid, in_ready, is_signed, out_valid, out_ready, busy;
      logic [31:0] a, b;
      logic [63:0] product;
      logic [63:0] exp_q[$];
      int          sent, rcvd;
      bit          done;

      seq_multiplier #(.DATA_WIDTH(32), .RADIX_BITS(R)) dut (
         .clock        (clk),
         .reset_n      (rst_r),
         .flush        (1'b0),
         .in_valid     (in_valid),
         .in_ready     (in_ready),
         .is_signed    (is_signed),
         .multiplicand (a),
         .multiplier   (b),
         .out_valid    (out_valid),
         .out_ready    (out_ready),
         .product      (product),
         .busy         (busy)
      );

      initial begin
         bit took;
         in_valid  = 1'b0;
         out_ready = 1'b0;
         is_signed = 1'b0;
         a         = '0;
         b         = '0;
         sent      = 0;
         rcvd      = 0;
         done      = 1'b0;
         took      = 1'b0;
         while (rst_r !== 1'b1) @(negedge clk);
         for (int cyc = 0; cyc < RND_LIMIT && rcvd < N_OPS; cyc++) begin
            @(negedge clk);
            if (took) in_valid = 1'b0;
            took      = 1'b0;
            out_ready = ($urandom_range(0, 3) != 0);
            if (!in_valid && sent < N_OPS && $urandom_range(0, 1) == 1) begin
               a         = rand_opnd();
               b         = rand_opnd();
               is_signed = $urandom_range(0, 1) == 1;
               in_valid  = 1'b1;
            end
            #1;
            if (out_valid && out_ready) begin
               if (exp_q.size() == 0) check_eq($sformatf("r%0d_spurious", R), 64'd1, 64'd0);
               else check_eq($sformatf("r%0d_prod", R), product, exp_q.pop_front());
               rcvd++;
            end
            if (in_valid && in_ready) begin
               exp_q.push_back(ref_mul(a, b, is_signed));
               sent++;
               took = 1'b1;
            end
         end
         check_eq($sformatf("r%0d_count", R), 64'(rcvd), 64'(N_OPS));
         done = 1'b1;
      end
   end

   // ---------------- directed sequence ----------------
   initial begin
      vec8_t vecs[5];
      int    lat;
      bit    busy_all;
      bit    flag;

      n_checks   = 0;
      n_fail     = 0;
      rst8       = 1'b0;
      rst_r      = 1'b0;
      flush8     = 1'b0;
      in_valid8  = 1'b0;
      out_ready8 = 1'b1;
      is_signed8 = 1'b0;
      a8         = '0;
      b8         = '0;

      #1;
      check_eq("rst_in_ready", 64'(in_ready8), 64'd1);
      check_eq("rst_out_valid", 64'(out_valid8), 64'd0);
      check_eq("rst_busy", 64'(busy8), 64'd0);
      check_eq("rst_product", 64'(product8), 64'd0);
      #24;
      rst8  = 1'b1;
      rst_r = 1'b1;

      start_op8(1'b0, 8'hFF, 8'hFF, 1'b1);
      wait_out8(lat, busy_all);
      check_eq("u255_lat", 64'(lat), 64'd5);
      check_eq("u255_busy", 64'(busy_all), 64'd1);
      check_eq("u255_prod", 64'(product8), 64'hFE01);

      vecs[0] = '{1'b1, 8'h80, 8'h80, 16'h4000};
      vecs[1] = '{1'b1, 8'hFF, 8'h7F, 16'hFF81};
      vecs[2] = '{1'b1, 8'h07, 8'hFD, 16'hFFEB};
      vecs[3] = '{1'b0, 8'h80, 8'h80, 16'h4000};
      vecs[4] = '{1'b0, 8'hFF, 8'h7F, 16'h7E81};
      foreach (vecs[i]) begin
         start_op8(vecs[i].s, vecs[i].a, vecs[i].b, 1'b1);
         wait_out8(lat, busy_all);
         check_eq($sformatf("vec%0d_lat", i), 64'(lat), 64'd5);
         check_eq($sformatf("vec%0d_prod", i), 64'(product8), 64'(vecs[i].exp));
      end

      // backpressure, then same-edge handoff into 3*4
      start_op8(1'b0, 8'd5, 8'd6, 1'b0);
      wait_out8(lat, busy_all);
      check_eq("bp_lat", 64'(lat), 64'd5);
      flag = 1'b1;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         #1;
         flag &= out_valid8 && (product8 == 16'h001E) && !in_ready8;
      end
      check_eq("bp_hold", 64'(flag), 64'd1);
      @(negedge clk);
      out_ready8 = 1'b1;
      is_signed8 = 1'b0;
      a8         = 8'd3;
      b8         = 8'd4;
      in_valid8  = 1'b1;
      #1;
      check_eq("b2b_in_ready", 64'(in_ready8), 64'd1);
      @(posedge clk);
      wait_out8(lat, busy_all);
      check_eq("b2b_lat", 64'(lat), 64'd5);
      check_eq("b2b_busy", 64'(busy_all), 64'd1);
      check_eq("b2b_prod", 64'(product8), 64'h000C);

      // asynchronous reset in CALC cycle 2
      start_op8(1'b0, 8'd9, 8'd7, 1'b1);
      @(negedge clk);
      in_valid8 = 1'b0;
      @(negedge clk);
      #2;
      rst8 = 1'b0;
      #1;
      check_eq("mid_rst_busy", 64'(busy8), 64'd0);
      check_eq("mid_rst_in_ready", 64'(in_ready8), 64'd1);
      check_eq("mid_rst_out_valid", 64'(out_valid8), 64'd0);
      check_eq("mid_rst_product", 64'(product8), 64'd0);
      @(negedge clk);
      rst8 = 1'b1;
      start_op8(1'b0, 8'd2, 8'd3, 1'b1);
      wait_out8(lat, busy_all);
      check_eq("post_rst_lat", 64'(lat), 64'd5);
      check_eq("post_rst_prod", 64'(product8), 64'h0006);

      // flush in CALC with a competing in_valid
      start_op8(1'b0, 8'd9, 8'd9, 1'b1);
      @(negedge clk);
      in_valid8 = 1'b0;
      @(negedge clk);
      flush8    = 1'b1;
      in_valid8 = 1'b1;
      a8        = 8'd1;
      b8        = 8'd1;
      #1;
      check_eq("flush_calc_in_ready", 64'(in_ready8), 64'd0);
      @(negedge clk);
      flush8    = 1'b0;
      in_valid8 = 1'b0;
      #1;
      check_eq("flush_calc_busy", 64'(busy8), 64'd0);
      flag = 1'b0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         #1;
         flag |= out_valid8 || busy8;
      end
      check_eq("flush_calc_quiet", 64'(flag), 64'd0);

      // flush in DONE
      start_op8(1'b0, 8'd4, 8'd4, 1'b0);
      wait_out8(lat, busy_all);
      check_eq("flush_done_lat", 64'(lat), 64'd5);
      check_eq("flush_done_prod", 64'(product8), 64'h0010);
      @(negedge clk);
      flush8     = 1'b1;
      in_valid8  = 1'b1;
      out_ready8 = 1'b1;
      #1;
      check_eq("flush_done_in_ready", 64'(in_ready8), 64'd0);
      @(negedge clk);
      flush8    = 1'b0;
      in_valid8 = 1'b0;
      #1;
      check_eq("flush_done_out_valid", 64'(out_valid8), 64'd0);
      check_eq("flush_done_busy", 64'(busy8), 64'd0);
      flag = 1'b0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         #1;
         flag |= out_valid8 || busy8;
      end
      check_eq("flush_done_quiet", 64'(flag), 64'd0);

      for (int i = 0; i < RND_LIMIT + 100 &&
           !(g_rnd[0].done && g_rnd[1].done && g_rnd[2].done); i++)
         @(negedge clk);
      check_eq("rnd_finished", 64'(g_rnd[0].done && g_rnd[1].done && g_rnd[2].done), 64'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
